bus_owner_ctrl: RTL and testbench

Sequencer and round-robin arbiter for a shared tri-state datapath bus driven by N output-enabled registers. It grants the bus to one requesting source at a time and drives that source's output enable. It strobes the destination register's load while the bus is driven. It also inserts a one-cycle turnaround so two sources never drive the bus together.

---
 rtl/bus_ctrl_pkg.sv | 16 +
 rtl/bus_owner_ctrl_rr_pick.sv | 36 +++
 rtl/bus_owner_ctrl.sv | 102 ++++++++++
 tb/tb_bus_owner_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus ownership controller.
//   state_t : controller states (IDLE/DRIVE/TURN), 2-bit encoding
//   owner_w : width of a source index for n sources, never below 1 bit
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_owner_ctrl_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req   [N-1:0] : request vector
//   ptr   [W-1:0] : last granted index; the scan starts at ptr+1
//   valid         : at least one request is set
//   idx   [W-1:0] : first requesting index at ptr+1, ptr+2, ... modulo N
module rr_pick
    import bus_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = owner_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    int cand;

    // Scan from the farthest offset down to the nearest so the closest
    // requester after ptr is the last one written and therefore wins.
    // Offset N is ptr itself: it only wins when nobody else requests.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_owner_ctrl.sv
// bus_owner_ctrl: round-robin owner sequencer for a shared tri-state bus.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   req       : per-source level request
//   oe / gnt  : per-source output enable / grant (identical, one-hot or 0)
//   load      : destination load strobe, high in every DRIVE cycle
//   owner     : current/last granted source, doubles as round-robin pointer
//   busy      : high in DRIVE and TURN
//   dbg_state : current controller state encoding
//
// Handshake: req is a level; a source owns the bus in every cycle its oe is
// high, and the sample of req at the edge ending a DRIVE cycle decides
// whether the grant continues. Every grant is followed by one TURN cycle
// with all enables low, so no two drivers ever overlap on the bus.
module bus_owner_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    output logic [N-1:0]          oe,
    output logic [N-1:0]          gnt,
    output logic                  load,
    output logic [owner_w(N)-1:0] owner,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int W  = owner_w(N);
    localparam int HW = owner_w(MAX_HOLD);

    state_t        state, state_n;
    logic [W-1:0]  owner_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          pick_valid;
    logic [W-1:0]  pick_idx;

    // One arbiter shared by IDLE and TURN; the owner register is the pointer.
    rr_pick #(.N(N), .W(W)) u_pick (
        .req   (req),
        .ptr   (owner),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= W'(N - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        hold_cnt_n = hold_cnt;
        unique case (state)
            IDLE, TURN: begin
                if (pick_valid) begin
                    state_n    = DRIVE;
                    owner_n    = pick_idx;
                    hold_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DRIVE: begin
                if (req[owner] && (int'(hold_cnt) < MAX_HOLD - 1)) begin
                    hold_cnt_n = hold_cnt + HW'(1);
                end else begin
                    state_n = TURN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state/owner, so an asynchronous
    // reset drops the enables immediately and req never reaches an output.
    always_comb begin
        oe = '0;
        if (state == DRIVE) begin
            oe[owner] = 1'b1;
        end
    end

    assign gnt       = oe;
    assign load      = (state == DRIVE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_owner_ctrl.sv
module tb_bus_owner_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    // clock / reset
    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] oe;
    logic [3:0] gnt;
    logic       load;
    logic [1:0] owner;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    bus_owner_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .oe        (oe),
        .gnt       (gnt),
        .load      (load),
        .owner     (owner),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // scoreboard: per-cycle expected records
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] oe;
        logic       load;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] o,
                       input logic b, input logic [1:0] ow);
        vec_t v;
        v.rst = r; v.req = rq; v.oe = o; v.load = |o; v.busy = b; v.owner = ow;
        vecs.push_back(v);
    endtask

    task automatic drv(input logic r, input logic [3:0] rq, input logic [1:0] ow);
        add(r, rq, 4'b0001 << ow, 1'b1, ow);
    endtask

    task automatic trn(input logic r, input logic [3:0] rq, input logic [1:0] ow);
        add(r, rq, 4'b0000, 1'b1, ow);
    endtask

    task automatic idl(input logic r, input logic [3:0] rq, input logic [1:0] ow);
        add(r, rq, 4'b0000, 1'b0, ow);
    endtask

    // driver: reset held low over two cycles, released on a falling edge
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clock);
        check("rst_oe",    32'(oe), 32'h0);
        check("rst_gnt",   32'(gnt), 32'h0);
        check("rst_load",  32'(load), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'(N - 1));
        check("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b1;
    endtask

    // invariant monitor, sampled on the falling edge
    logic [3:0] prev_oe;
    int         run_len;

    always @(negedge clock) begin
        if (reset) begin
            check("mon_onehot", 32'($countones(oe) <= 1), 32'h1);
            check("mon_load",   32'(load), 32'(|oe));
            check("mon_gnt",    32'(gnt), 32'(oe));
            if (oe != 0) check("mon_busy", 32'(busy), 32'h1);
            if (prev_oe != 0 && oe != 0)
                check("mon_gap", 32'(oe), 32'(prev_oe));
            run_len = (oe != 0) ? run_len + 1 : 0;
            check("mon_hold", 32'(run_len <= MAX_HOLD), 32'h1);
            prev_oe = oe;
        end else begin
            prev_oe = '0;
            run_len = 0;
        end
    end

    initial begin
        reset   = 1'b0;
        req     = '0;
        prev_oe = '0;
        run_len = 0;

        // single request of two cycles, then turnaround and idle
        drv(1, 4'b0100, 2); drv(0, 4'b0100, 2); trn(0, 4'b0000, 2);
        idl(0, 4'b0000, 2); idl(0, 4'b0000, 2);
        // arbitration from IDLE with pointer 2: source 3 first, then wrap to 0
        drv(0, 4'b1011, 3); drv(0, 4'b1011, 3); trn(0, 4'b0011, 3);
        drv(0, 4'b0011, 0); trn(0, 4'b0000, 0); idl(0, 4'b0000, 0);
        // round-robin under full contention from reset: 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < MAX_HOLD; k++)
                drv((g == 0 && k == 0), 4'b1111, 2'(g % 4));
            trn(0, 4'b1111, 2'(g % 4));
        end
        idl(0, 4'b0000, 0);
        // hold limit with a lone requester
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < MAX_HOLD; k++)
                drv((g == 0 && k == 0), 4'b0001, 0);
            trn(0, 4'b0001, 0);
        end
        drv(0, 4'b0001, 0); trn(0, 4'b0000, 0); idl(0, 4'b0000, 0);
        // pointer wrap: after source 3, req 1010 goes to 1 then 3
        drv(1, 4'b1000, 3); trn(0, 4'b0000, 3); drv(0, 4'b1010, 1);
        drv(0, 4'b1010, 1); trn(0, 4'b1000, 1); drv(0, 4'b1000, 3);
        trn(0, 4'b0000, 3); idl(0, 4'b0000, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clock);
            req = vecs[i].req;
            @(posedge clock);
            #1;
            check($sformatf("v%0d_oe", i),    32'(oe),    32'(vecs[i].oe));
            check($sformatf("v%0d_load", i),  32'(load),  32'(vecs[i].load));
            check($sformatf("v%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
            check($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
        end

        // asynchronous reset in the middle of a DRIVE cycle
        do_reset();
        req = 4'b0001;
        @(posedge clock);
        #1;
        check("ar_drive_oe", 32'(oe), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_oe",    32'(oe), 32'h0);
        check("ar_load",  32'(load), 32'h0);
        check("ar_busy",  32'(busy), 32'h0);
        check("ar_owner", 32'(owner), 32'h3);
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b1001;
        @(posedge clock);
        #1;
        check("ar_first_oe", 32'(oe), 32'h1);
        @(negedge clock);
        req = 4'b1000;
        @(posedge clock);
        #1;
        check("ar_turn_oe",   32'(oe), 32'h0);
        check("ar_turn_busy", 32'(busy), 32'h1);
        @(posedge clock);
        #1;
        check("ar_src3_oe",    32'(oe), 32'h8);
        check("ar_src3_owner", 32'(owner), 32'h3);

        // random traffic under the invariant monitor
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            req = 4'($urandom_range(0, 15));
        end
        @(negedge clock);
        req = '0;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
